// File: rtl/rf_pkg.sv
// Shared sizing and grant encoding for the register-file write scheduler.
package rf_pkg;

  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int DW     = 16;
  localparam int PEND_W = 2;

  // Identifies which writeback source owns the port (also the round-robin priority value).
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

endpackage

// File: rtl/rf_write_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational and the priority flop
// favours the source that was not granted most recently.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  src_e prio;

  // Pick a winner this cycle. Nothing is granted while reset is held.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) begin
        if (prio == SRC_ALU) gnt = 2'b01;
        else                 gnt = 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Hand priority to the other source after a grant. Hold it when the port is idle.
  always_ff @(posedge clk) begin
    if (rst)         prio <= SRC_ALU;
    else if (gnt[0]) prio <= SRC_LD;
    else if (gnt[1]) prio <= SRC_ALU;
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Shares the register file's single write port between the ALU and the load unit.
// It also tracks how many writes are outstanding for each register, so issue logic
// can detect hazards.
module rf_write_scheduler
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_reg,
  output logic            alloc_ready,
  input  logic            src0_valid,
  output logic            src0_ready,
  input  logic [AW-1:0]   src0_reg,
  input  logic [DW-1:0]   src0_data,
  input  logic            src1_valid,
  output logic            src1_ready,
  input  logic [AW-1:0]   src1_reg,
  input  logic [DW-1:0]   src1_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_write_reg,
  output logic [DW-1:0]   rf_write_data,
  input  logic [AW-1:0]   chk_reg1,
  input  logic [AW-1:0]   chk_reg2,
  output logic            chk_busy1,
  output logic            chk_busy2,
  output logic [NREG-1:0] busy_vec,
  output logic            err_underflow
);

  logic [1:0]        gnt;
  logic [PEND_W-1:0] pend_cnt [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic [NREG-1:0]   zero_vec;
  logic              underflow_now;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({src1_valid, src0_valid}),
    .gnt (gnt)
  );

  assign src0_ready = gnt[SRC_ALU];
  assign src1_ready = gnt[SRC_LD];

  // Steer the granted source onto the write port. The port drives zeros when idle.
  always_comb begin
    rf_we         = |gnt;
    rf_write_reg  = '0;
    rf_write_data = '0;
    if (gnt[SRC_ALU]) begin
      rf_write_reg  = src0_reg;
      rf_write_data = src0_data;
    end else if (gnt[SRC_LD]) begin
      rf_write_reg  = src1_reg;
      rf_write_data = src1_data;
    end
  end

  // A saturated counter stalls further reservations instead of wrapping.
  assign alloc_ready = ~rst & (pend_cnt[alloc_reg] != {PEND_W{1'b1}});

  // Decode this cycle's reservation and retirement per register and flag any retire that hits zero.
  always_comb begin
    inc_vec  = '0;
    dec_vec  = '0;
    zero_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_vec[r]  = alloc_valid & alloc_ready & (alloc_reg == AW'(r));
      dec_vec[r]  = rf_we & (rf_write_reg == AW'(r));
      zero_vec[r] = (pend_cnt[r] == '0);
    end
    underflow_now = |(dec_vec & ~inc_vec & zero_vec);
  end

  // Pending-write counters. A simultaneous reserve and retire cancels out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) pend_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          pend_cnt[r] <= pend_cnt[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r] && !zero_vec[r])
          pend_cnt[r] <= pend_cnt[r] - 1'b1;
      end
    end
  end

  // Sticky error flag. It is cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                err_underflow <= 1'b0;
    else if (underflow_now) err_underflow <= 1'b1;
  end

  // Busy status comes from registered counts only, so a retiring write still reads busy.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) busy_vec[r] = ~zero_vec[r];
  end

  assign chk_busy1 = busy_vec[chk_reg1];
  assign chk_busy2 = busy_vec[chk_reg2];

endmodule
